// File: rtl/fisqrt_rr_scheduler.sv
// fisqrt_rr_scheduler
//   Round-robin front end that shares one iterative fastInvSqrt unit
//   (half-precision 1/sqrt(x)) among NREQ requesters. A winner is picked in
//   IDLE. Its operand is captured and held on unit_x. The unit is launched by
//   pulsing unit_start, and the scheduler then waits for unit_done. A
//   watchdog bounds that wait and returns a quiet NaN if the unit never
//   answers.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req, req_x          per-requester request and FP16 operand (16 bits each)
//   req_ack             one-hot, one-cycle grant/capture pulse
//   unit_x, unit_start  operand and reset/start drive to the shared unit
//   unit_done, unit_result, unit_ofuf   completion, result and flags from the unit
//   busy                high in any state but IDLE
//   rsp_valid           one-cycle response strobe
//   rsp_id, rsp_result, rsp_ofuf, rsp_timeout   response fields, held until the next response
//
// state  | meaning
// IDLE   | scan requests round-robin, capture the winner
// LAUNCH | unit_start high for START_LEN cycles
// WAIT   | count cycles, accept done after GUARD, abort at TIMEOUT
// RESP   | rsp_valid strobe, back to IDLE
module fisqrt_rr_scheduler #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int START_LEN = 1,
  parameter int GUARD     = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   req_ack,
  output logic [15:0]       unit_x,
  output logic              unit_start,
  input  logic              unit_done,
  input  logic [15:0]       unit_result,
  input  logic [1:0]        unit_ofuf,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_result,
  output logic [1:0]        rsp_ofuf,
  output logic              rsp_timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // One counter serves both the launch length and the wait watchdog.
  localparam int CMAX = (TIMEOUT > START_LEN) ? TIMEOUT : START_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [15:0] QNAN = 16'h7E00;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cur_id;
  logic [CW-1:0]  cnt;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] scan_idx;

  // Scan from ptr+1 upward (mod NREQ); the most recent winner is looked at
  // last, so a requester holding req after its ack yields to the others.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // Reset also holds the shared unit in reset, so a mid-operation abort
  // leaves it clean for the next launch.
  assign unit_start = reset || (state == LAUNCH);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDW'(NREQ - 1);
      cur_id      <= '0;
      cnt         <= '0;
      req_ack     <= '0;
      unit_x      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_ofuf    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            req_ack <= NREQ'(1) << win;
            unit_x  <= req_x[16*win +: 16];
            cur_id  <= win;
            ptr     <= win;
            cnt     <= '0;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == CW'(START_LEN - 1)) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // A done seen inside the guard window is left over from the
          // previous operation. A real done takes priority over the
          // watchdog when both land in the same cycle.
          if (unit_done && (cnt >= CW'(GUARD))) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_result  <= unit_result;
            rsp_ofuf    <= unit_ofuf;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_result  <= QNAN;
            rsp_ofuf    <= 2'b00;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fisqrt_rr_scheduler.sv
module tb_fisqrt_rr_scheduler;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_x;
  logic [3:0]  req_ack;
  logic [15:0] unit_x;
  logic        unit_start;
  logic        unit_done   = 1'b0;
  logic [15:0] unit_result = 16'h0000;
  logic [1:0]  unit_ofuf   = 2'b00;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_ofuf;
  logic        rsp_timeout;

  fisqrt_rr_scheduler #(
    .NREQ(4), .IDW(2), .START_LEN(1), .GUARD(1), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_ack(req_ack),
    .unit_x(unit_x), .unit_start(unit_start), .unit_done(unit_done),
    .unit_result(unit_result), .unit_ofuf(unit_ofuf), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ofuf(rsp_ofuf), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stub of the shared unit. It knows two reference points of the real
  // fastInvSqrt and uses a fixed scramble for any other operand.
  function automatic logic [15:0] model_res(input logic [15:0] x);
    case (x)
      16'h50BB: return 16'h3133;
      16'h4DE1: return 16'h3298;
      default:  return (x ^ 16'h5A5A) + 16'h0101;
    endcase
  endfunction

  function automatic logic [1:0] model_ofuf(input logic [15:0] x);
    return {x[4], x[0]};
  endfunction

  // mode 0: done after lat cycles. mode 1: done never comes.
  // mode 2: a stale done (0xDEAD) is held while the unit is started; the
  //         real done follows later.
  int   mode = 0;
  int   lat  = 2;
  int   phase = 0;
  logic sbusy = 1'b0;

  always @(posedge clk) begin
    unit_done <= 1'b0;
    if (unit_start) begin
      phase <= 0;
      sbusy <= 1'b1;
      if (mode == 2) begin
        unit_done   <= 1'b1;
        unit_result <= 16'hDEAD;
        unit_ofuf   <= 2'b10;
      end
    end else if (sbusy) begin
      phase <= phase + 1;
      if (mode != 1 && phase == lat) begin
        unit_done   <= 1'b1;
        unit_result <= model_res(unit_x);
        unit_ofuf   <= model_ofuf(unit_x);
        sbusy       <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
    logic [1:0]  ofuf;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  logic [3:0]  last_req = 4'h0;
  logic [63:0] last_x   = 64'h0;
  int          mptr = NREQ - 1;
  int          w;
  exp_t        e;

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // The monitor samples on the falling edge. An ack seen now came from the
  // request value that was present at the previous falling edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      mptr = NREQ - 1;
    end else begin
      if (req_ack != 4'h0) begin
        w = rr_pick(mptr, last_req);
        check_val("ack_grant", {28'h0, req_ack}, 32'd1 << w);
        if (w >= 0) begin
          check_val("unit_x", {16'h0, unit_x}, {16'h0, last_x[16*w +: 16]});
          mptr = w;
          grant_log.push_back(w);
          if (mode == 1) e = '{id: 2'(w), res: 16'h7E00, ofuf: 2'b00, to: 1'b1};
          else e = '{id: 2'(w), res: model_res(last_x[16*w +: 16]),
                     ofuf: model_ofuf(last_x[16*w +: 16]), to: 1'b0};
          sb.push_back(e);
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check_val("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("rsp_id", {30'h0, rsp_id}, {30'h0, e.id});
          check_val("rsp_result", {16'h0, rsp_result}, {16'h0, e.res});
          check_val("rsp_ofuf", {30'h0, rsp_ofuf}, {30'h0, e.ofuf});
          check_val("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.to});
        end
      end
    end
    last_req = req;
    last_x   = req_x;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    check_val("rst_unit_start", {31'h0, unit_start}, 32'd1);
    check_val("rst_busy", {31'h0, busy}, 32'd0);
    check_val("rst_req_ack", {28'h0, req_ack}, 32'd0);
    check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check_val("rst_unit_x", {16'h0, unit_x}, 32'd0);
    check_val("rst_rsp_fields", {11'h0, rsp_id, rsp_result, rsp_ofuf, rsp_timeout}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic issue(input int id, input logic [15:0] x);
    bit got = 1'b0;
    req_x[16*id +: 16] = x;
    req[id] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_ack[id]) begin
        got = 1'b1;
        break;
      end
    end
    req[id] = 1'b0;
    if (!got) check_val("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done_ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sb.size() == 0 && !busy) begin
        done_ok = 1'b1;
        break;
      end
    end
    if (!done_ok) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int  n;
    bit  got;
    reset = 1'b1;
    req   = 4'h0;
    req_x = 64'h0;
    do_reset(3);

    // Single requests against the reference operands.
    issue(0, 16'h50BB);
    wait_idle();
    issue(2, 16'h4DE1);
    wait_idle();

    // All four requests held: the grant order must rotate starting at req0.
    do_reset(2);
    grant_log.delete();
    req_x = {16'h3C00, 16'h4000, 16'h4400, 16'h4800};
    req   = 4'hF;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (req_ack != 4'h0) n++;
      if (n == 5) break;
    end
    req = 4'h0;
    check_val("rr_grants", n, 5);
    wait_idle();
    check_val("rr_log_size", grant_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check_val("rr_order", grant_log[i], exp_order[i]);
    end

    // The unit never answers, so the watchdog must fire. The response comes
    // 1 LAUNCH cycle plus 64 WAIT cycles after the ack cycle.
    mode = 1;
    issue(1, 16'h3C00);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (rsp_valid) break;
    end
    check_val("timeout_latency", n, 65);
    wait_idle();
    mode = 0;

    // A stale done inside the guard window must be ignored.
    mode = 2;
    issue(3, 16'h4400);
    wait_idle();
    mode = 0;

    // Reset while in WAIT with req3 pending. After release, req0 must win.
    lat = 30;
    issue(2, 16'h4C00);
    repeat (5) tick();
    req_x[63:48] = 16'h3800;
    req_x[15:0]  = 16'h3400;
    req[3] = 1'b1;
    req[0] = 1'b1;
    lat = 2;
    do_reset(2);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ack != 4'h0) begin
        got = 1'b1;
        break;
      end
    end
    check_val("rst_first_grant", {28'h0, req_ack}, 32'h1);
    req[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_ack[3]) begin
        got = 1'b1;
        break;
      end
    end
    req[3] = 1'b0;
    check_val("rst_second_grant", {31'h0, got}, 32'd1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
